// File: rtl/char_writer.sv
// char_writer: terminal-style writer into the 70x30 text-mode character buffer.
// Accepts ASCII codes, keeps the cursor, and handles line wrap, newline,
// backspace and full-screen clear. The write address matches the display's
// read address layout.
//   clk_50m, clrn      : clock, asynchronous active-low reset
//   ascii_in/valid     : code input, accepted when ascii_valid & ready
//   ready              : high only while idle
//   char_wr_en/addr/data : buffer write port, {4'b0, row[4:0], col[6:0]}
//   cur_h, cur_v       : cursor column / row
module char_writer (
    input  logic        clk_50m,
    input  logic        clrn,
    input  logic [7:0]  ascii_in,
    input  logic        ascii_valid,
    output logic        ready,
    output logic        char_wr_en,
    output logic [15:0] char_wr_addr,
    output logic [7:0]  char_wr_data,
    output logic [6:0]  cur_h,
    output logic [4:0]  cur_v
);

    localparam int unsigned COLS  = 70;
    localparam int unsigned ROWS  = 30;
    localparam int unsigned COL_W = 7;
    localparam int unsigned ROW_W = 5;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] LINE_FULL = COL_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [7:0]       SPACE     = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        LINE_CLR = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   clr_col, clr_col_nxt;
    logic [ROW_W-1:0]   clr_row, clr_row_nxt;
    logic [COL_W-1:0]   cur_h_nxt;
    logic [ROW_W-1:0]   cur_v_nxt;
    logic [COL_W-1:0]   line_end [ROWS];

    logic               wr_en_nxt;
    logic [ROW_W-1:0]   wr_row;
    logic [COL_W-1:0]   wr_col;
    logic [7:0]         wr_data_nxt;

    logic               le_wr;
    logic               le_clr;
    logic [ROW_W-1:0]   le_idx;
    logic [COL_W-1:0]   le_val;

    logic               accept;
    logic               is_print;
    logic [ROW_W-1:0]   next_v;
    logic [ROW_W-1:0]   prev_v;
    logic [COL_W-1:0]   prev_end;

    assign accept   = ascii_valid & ready & (state == IDLE);
    assign is_print = (ascii_in >= 8'h20) && (ascii_in <= 8'h7E);
    assign next_v   = (cur_v == LAST_ROW) ? '0 : cur_v + ROW_W'(1);
    // Guarded so the line_end lookup never indexes past the array
    assign prev_v   = (cur_v == '0) ? LAST_ROW : cur_v - ROW_W'(1);
    assign prev_end = line_end[prev_v];

    // Next-state, cursor, line_end update and write-port decode
    always_comb begin
        state_nxt   = state;
        clr_col_nxt = clr_col;
        clr_row_nxt = clr_row;
        cur_h_nxt   = cur_h;
        cur_v_nxt   = cur_v;
        wr_en_nxt   = 1'b0;
        wr_row      = clr_row;
        wr_col      = clr_col;
        wr_data_nxt = SPACE;
        le_wr       = 1'b0;
        le_clr      = 1'b0;
        le_idx      = cur_v;
        le_val      = cur_h;

        unique case (state)
            CLR_ALL: begin
                wr_en_nxt = 1'b1;
                if (clr_col == LAST_COL) begin
                    clr_col_nxt = '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        clr_row_nxt = clr_row + ROW_W'(1);
                    end
                end else begin
                    clr_col_nxt = clr_col + COL_W'(1);
                end
            end

            LINE_CLR: begin
                wr_en_nxt = 1'b1;
                if (clr_col == LAST_COL) begin
                    clr_col_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    clr_col_nxt = clr_col + COL_W'(1);
                end
            end

            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        wr_en_nxt   = 1'b1;
                        wr_row      = cur_v;
                        wr_col      = cur_h;
                        wr_data_nxt = ascii_in;
                        if (cur_h == LAST_COL) begin
                            le_wr       = 1'b1;
                            le_val      = LINE_FULL;
                            cur_h_nxt   = '0;
                            cur_v_nxt   = next_v;
                            clr_row_nxt = next_v;
                            clr_col_nxt = '0;
                            state_nxt   = LINE_CLR;
                        end else begin
                            cur_h_nxt = cur_h + COL_W'(1);
                        end
                    end else if (ascii_in == 8'h0A || ascii_in == 8'h0D) begin
                        le_wr       = 1'b1;
                        cur_h_nxt   = '0;
                        cur_v_nxt   = next_v;
                        clr_row_nxt = next_v;
                        clr_col_nxt = '0;
                        state_nxt   = LINE_CLR;
                    end else if (ascii_in == 8'h08) begin
                        if (cur_h != '0) begin
                            wr_en_nxt = 1'b1;
                            wr_row    = cur_v;
                            wr_col    = cur_h - COL_W'(1);
                            cur_h_nxt = cur_h - COL_W'(1);
                        end else if (cur_v != '0) begin
                            // Back onto the previous row: a full row means the
                            // wrap consumed column 69, so erase it as well
                            cur_v_nxt = prev_v;
                            if (prev_end == LINE_FULL) begin
                                wr_en_nxt = 1'b1;
                                wr_row    = prev_v;
                                wr_col    = LAST_COL;
                                cur_h_nxt = LAST_COL;
                            end else begin
                                cur_h_nxt = prev_end;
                            end
                        end
                    end else if (ascii_in == 8'h0C) begin
                        le_clr      = 1'b1;
                        cur_h_nxt   = '0;
                        cur_v_nxt   = '0;
                        clr_row_nxt = '0;
                        clr_col_nxt = '0;
                        state_nxt   = CLR_ALL;
                    end
                end
            end

            default: begin
                state_nxt   = CLR_ALL;
                clr_row_nxt = '0;
                clr_col_nxt = '0;
            end
        endcase
    end

    // State, cursor, line_end and registered outputs
    always_ff @(posedge clk_50m or negedge clrn) begin
        if (!clrn) begin
            state        <= CLR_ALL;
            clr_col      <= '0;
            clr_row      <= '0;
            cur_h        <= '0;
            cur_v        <= '0;
            ready        <= 1'b0;
            char_wr_en   <= 1'b0;
            char_wr_addr <= '0;
            char_wr_data <= '0;
            for (int i = 0; i < int'(ROWS); i++) begin
                line_end[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            clr_col    <= clr_col_nxt;
            clr_row    <= clr_row_nxt;
            cur_h      <= cur_h_nxt;
            cur_v      <= cur_v_nxt;
            ready      <= (state_nxt == IDLE);
            char_wr_en <= wr_en_nxt;
            if (wr_en_nxt) begin
                char_wr_addr <= {4'b0000, wr_row, wr_col};
                char_wr_data <= wr_data_nxt;
            end
            if (le_clr) begin
                for (int i = 0; i < int'(ROWS); i++) begin
                    line_end[i] <= '0;
                end
            end else if (le_wr) begin
                line_end[le_idx] <= le_val;
            end
        end
    end

endmodule

// File: tb/tb_char_writer.sv
// tb_char_writer: scoreboard bench for char_writer. A behavioural terminal
// model queues every expected buffer write; a monitor pops and compares each
// write the DUT presents. The driver also checks cursor and busy lengths.
module tb_char_writer;

    logic        clk_50m;
    logic        clrn;
    logic [7:0]  ascii_in;
    logic        ascii_valid;
    logic        ready;
    logic        char_wr_en;
    logic [15:0] char_wr_addr;
    logic [7:0]  char_wr_data;
    logic [6:0]  cur_h;
    logic [4:0]  cur_v;

    char_writer dut (
        .clk_50m      (clk_50m),
        .clrn         (clrn),
        .ascii_in     (ascii_in),
        .ascii_valid  (ascii_valid),
        .ready        (ready),
        .char_wr_en   (char_wr_en),
        .char_wr_addr (char_wr_addr),
        .char_wr_data (char_wr_data),
        .cur_h        (cur_h),
        .cur_v        (cur_v)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_seen = 0;

    // Terminal model: cursor and per-row leave column
    int m_h, m_v;
    int m_le [30];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push_wr(input int r, input int c, input logic [7:0] d);
        wr_t w;
        w.addr = 16'(r * 128 + c);
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        m_h = 0;
        m_v = 0;
        for (int i = 0; i < 30; i++) m_le[i] = 0;
    endtask

    task automatic model_clear_all();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 70; c++)
                push_wr(r, c, 8'h20);
        model_reset();
    endtask

    task automatic model_newline(input int leave_col);
        m_le[m_v] = leave_col;
        m_v = (m_v + 1) % 30;
        m_h = 0;
        for (int c = 0; c < 70; c++) push_wr(m_v, c, 8'h20);
    endtask

    // Applies one accepted code; busy = expected ready-low cycles afterwards
    task automatic model_apply(input logic [7:0] code, output int busy);
        busy = 0;
        if (code >= 8'h20 && code <= 8'h7E) begin
            push_wr(m_v, m_h, code);
            if (m_h == 69) begin
                model_newline(70);
                busy = 70;
            end else begin
                m_h++;
            end
        end else if (code == 8'h0A || code == 8'h0D) begin
            model_newline(m_h);
            busy = 70;
        end else if (code == 8'h08) begin
            if (m_h > 0) begin
                m_h--;
                push_wr(m_v, m_h, 8'h20);
            end else if (m_v > 0) begin
                m_v--;
                if (m_le[m_v] == 70) begin
                    m_h = 69;
                    push_wr(m_v, 69, 8'h20);
                end else begin
                    m_h = m_le[m_v];
                end
            end
        end else if (code == 8'h0C) begin
            model_clear_all();
            busy = 2100;
        end
    endtask

    // Monitor: every presented write must be the next expected one
    always @(posedge clk_50m) begin
        wr_t e;
        #1;
        if (clrn && char_wr_en) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h@%h expected none", char_wr_data, char_wr_addr);
            end else begin
                e = exp_q.pop_front();
                if (e.addr !== char_wr_addr || e.data !== char_wr_data) begin
                    errors++;
                    $display("FAIL write_%0d got %h@%h expected %h@%h",
                             wr_seen, char_wr_data, char_wr_addr, e.data, e.addr);
                end
            end
        end
    end

    // Counts ready-low negedges; pokes ignored codes at the busy DUT
    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_50m);
            if (ready === 1'b1) begin
                ascii_valid = 1'b0;
                return;
            end
            cnt++;
            ascii_valid = ($urandom_range(0, 3) == 0);
            ascii_in    = 8'($urandom_range(0, 255));
        end
        ascii_valid = 1'b0;
        chk("ready_timeout", 0, 1);
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_cur_h"}, int'(cur_h), m_h);
        chk({tag, "_cur_v"}, int'(cur_v), m_v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_wr_en"}, int'(char_wr_en), 0);
        chk({tag, "_wr_addr"}, int'(char_wr_addr), 0);
        chk({tag, "_wr_data"}, int'(char_wr_data), 0);
        chk({tag, "_cur_h"}, int'(cur_h), 0);
        chk({tag, "_cur_v"}, int'(cur_v), 0);
    endtask

    task automatic send(input logic [7:0] code);
        int busy, cnt;
        @(negedge clk_50m);
        chk("ready_before_send", int'(ready), 1);
        ascii_in    = code;
        ascii_valid = 1'b1;
        model_apply(code, busy);
        @(posedge clk_50m);
        #1;
        ascii_valid = 1'b0;
        check_cursor("send");
        chk("ready_after_accept", int'(ready), (busy == 0) ? 1 : 0);
        if (busy != 0) begin
            wait_ready(cnt);
            chk("busy_cycles", cnt, busy);
        end
    endtask

    task automatic release_and_clear(input string tag);
        int cnt;
        @(negedge clk_50m);
        clrn = 1'b1;
        model_clear_all();
        wait_ready(cnt);
        chk({tag, "_busy"}, cnt, 2099);
        chk({tag, "_drained"}, exp_q.size(), 0);
        check_cursor(tag);
    endtask

    function automatic logic [7:0] rand_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      return 8'($urandom_range(32, 126));
        else if (r < 76) return 8'h0A;
        else if (r < 80) return 8'h0D;
        else if (r < 92) return 8'h08;
        else if (r < 93) return 8'h0C;
        else if (r < 96) return 8'($urandom_range(128, 255));
        else             return (r < 98) ? 8'h7F : 8'h1B;
    endfunction

    initial begin
        int base, burst;
        clrn        = 1'b0;
        ascii_in    = 8'h00;
        ascii_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_50m);
        check_reset_outputs("reset");
        release_and_clear("init");

        // Back-to-back printables
        send(8'h41);
        send(8'h42);

        // Full row 0 then wrap, then backspace across the wrap
        send(8'h0C);
        for (int i = 0; i < 70; i++) send(8'($urandom_range(32, 126)));
        send(8'h08);
        chk("bs_wrap_h", int'(cur_h), 69);
        chk("bs_wrap_v", int'(cur_v), 0);

        // "hi", newline, backspace back to end of text
        send(8'h0A);
        send(8'h68);
        send(8'h69);
        send(8'h0A);
        send(8'h08);
        chk("bs_nl_h", int'(cur_h), 2);

        // Walk to row 29, then newline wraps to row 0
        while (m_v != 29) send(8'h0D);
        send(8'h0A);
        chk("row_wrap_v", int'(cur_v), 0);

        // Full clear with ignored pokes during busy
        send(8'h0C);

        // Random traffic with occasional long printable bursts
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                burst = $urandom_range(60, 80);
                for (int j = 0; j < burst; j++) send(8'($urandom_range(32, 126)));
            end else begin
                send(rand_code());
            end
        end

        // Reset partway through a clear
        @(negedge clk_50m);
        chk("ready_before_clr", int'(ready), 1);
        ascii_in    = 8'h0C;
        ascii_valid = 1'b1;
        begin
            int busy;
            model_apply(8'h0C, busy);
        end
        @(posedge clk_50m);
        #1;
        ascii_valid = 1'b0;
        base = wr_seen;
        for (int i = 0; i < 1000 && (wr_seen - base) < 500; i++) @(negedge clk_50m);
        chk("mid_clear_writes", wr_seen - base, 500);
        clrn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        model_reset();
        repeat (3) @(negedge clk_50m);
        chk("held_wr_en", int'(char_wr_en), 0);
        release_and_clear("restart");

        send(8'h5A);
        repeat (3) @(negedge clk_50m);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1900000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
